// File: rtl/rr_burst_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter:
// state encoding and width helpers.
package rr_burst_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_mux.sv
// Keyed data select: entry i is chosen when key == i.
// Ports: key in, packed data_in (entry i at slice i), out.
module mux_key #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8
) (
  input  logic [KEY_LEN-1:0]         key,
  input  logic [NR_KEY*DATA_LEN-1:0] data_in,
  output logic [DATA_LEN-1:0]        out
);

  logic [DATA_LEN-1:0] hit [NR_KEY];

  for (genvar i = 0; i < NR_KEY; i++) begin : g_lut
    localparam logic [KEY_LEN-1:0] K = KEY_LEN'(i);
    assign hit[i] = (key == K) ?
      data_in[i*DATA_LEN +: DATA_LEN] : '0;
  end

  always_comb begin
    out = '0;
    for (int j = 0; j < NR_KEY; j++) out = out | hit[j];
  end

endmodule

// File: rtl/rr_burst_arbiter_pick.sv
// Rotating-priority picker: first valid requester at or after ptr.
// Ports: req_valid, ptr in; winner index and any-valid flag out.
module rr_pick
  import rr_burst_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  int idx;

  // Scan from farthest to nearest offset so the
  // nearest valid requester is the last to overwrite.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one grant per burst, ended by
// req_last or MAX_BURST beats. Ports: req_* in, out_* stream, grant_id, busy.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = id_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  localparam int CNT_W = cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  ID_TOP  = ID_W'(NREQ - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0] winner;
  logic            any;
  logic            active;
  logic            hs;
  logic [ID_W-1:0] ptr_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any       (any)
  );

  mux_key #(
    .NR_KEY   (NREQ),
    .KEY_LEN  (ID_W),
    .DATA_LEN (DATA_W)
  ) u_mux (
    .key     (grant_q),
    .data_in (req_data),
    .out     (out_data)
  );

  assign grant_id = grant_q;
  assign ptr_nxt  = (grant_q == ID_TOP) ? '0 : grant_q + 1'b1;

  // Outputs are masked while rst_n is low so an abandoned
  // burst cannot complete a handshake in the reset cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    active    = rst_n & (state_q == ARB_GRANT);
    busy      = active;
    out_valid = active & req_valid[grant_q];
    out_last  = active &
      (req_last[grant_q] | (cnt_q == CNT_END));
    req_ready = '0;
    if (active) req_ready[grant_q] = out_ready;
    hs = out_valid & out_ready;
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (out_last) begin
            state_d = ARB_IDLE;
            ptr_d   = ptr_nxt;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
